fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The block SHALL have parameter IMEM_DEPTH, default 1024, meaning the instruction memory depth in 32-bit words (power of two).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 The block SHALL have port stall, input, 1, meaning hold the PC and the IF/ID register (load-use hazard).
REQ-006 The block SHALL have port flush, input, 1, meaning replace the IF/ID contents with a bubble.
REQ-007 The block SHALL have port redirect_valid, input, 1, meaning a taken branch or jump resolved in EX.
REQ-008 The block SHALL have port redirect_pc, input, 32, the branch/jump target.
REQ-009 The block SHALL have port pc, output, 32, the current fetch PC.
REQ-010 The block SHALL have port if_id_pc, output, 32, the PC of the instruction held in IF/ID.
REQ-011 The block SHALL have port if_id_pc4, output, 32, equal to if_id_pc + 4.
REQ-012 The block SHALL have port if_id_instr, output, 32, the instruction held in IF/ID.
REQ-013 The block SHALL have port if_id_valid, output, 1, which is 0 for a bubble.
REQ-014 The block SHALL have port misaligned_err, output, 1, a sticky flag for a misaligned redirect target.

Function
REQ-015 The block SHALL hold an internal array imem[0:IMEM_DEPTH-1] of 32-bit words, named exactly imem so the bench can load it by hierarchical $readmemh.
REQ-016 imem SHALL be read asynchronously at index pc[log2(IMEM_DEPTH)+1:2]; addresses beyond the depth wrap modulo IMEM_DEPTH.
REQ-017 Fetch latency SHALL be one cycle: the word at pc is captured into IF/ID on the next edge, together with if_id_pc = pc and if_id_valid = 1.
REQ-018 Update priority SHALL be rst > redirect_valid > stall > normal. Flush affects IF/ID only.
REQ-019 On redirect_valid, pc SHALL be set to {redirect_pc[31:2], 2'b00} and IF/ID SHALL take a bubble, regardless of stall and flush.
REQ-020 On stall without redirect, pc SHALL hold. IF/ID SHALL also hold, unless flush is asserted, in which case IF/ID takes a bubble.
REQ-021 On flush without stall or redirect, pc SHALL advance by 4 and IF/ID SHALL take a bubble.
REQ-022 On a normal cycle, pc SHALL become pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-023 A bubble SHALL be: if_id_instr = 32'h0000_0013 (NOP), if_id_valid = 0, and if_id_pc unchanged.
REQ-024 misaligned_err SHALL set on an edge where redirect_valid = 1 and redirect_pc[1:0] != 0, and SHALL remain set until rst.

Reset
REQ-025 While rst is high at an edge: pc = RESET_PC, if_id_pc = 0, if_id_instr = 32'h0000_0013, if_id_valid = 0, misaligned_err = 0, and counters = 0.
REQ-026 If rst is asserted mid-operation, it SHALL override any concurrent stall, flush, or redirect. imem contents SHALL be unaffected.
REQ-027 On the first edge after rst deasserts, IF/ID SHALL hold imem[RESET_PC>>2] with if_id_valid = 1.

Configuration
REQ-028 When macro FETCH_PERF_CNT_EN is defined, the block SHALL add a 32-bit output fetch_count and a 32-bit output stall_count:
- fetch_count increments on every edge where a valid instruction enters IF/ID.
- stall_count increments on every edge where stall = 1 and redirect_valid = 0.
- Both counters wrap at 2^32.
REQ-029 When FETCH_PERF_CNT_EN is undefined, these ports and counters SHALL be absent, with no other behavioural change.

Verification
REQ-030 Sequential fetch: imem[0..3] = 13,93,113,193 (hex, low bytes); release rst -> if_id_instr follows imem[0], imem[1], imem[2], imem[3] on consecutive cycles; pc = 4, 8, 12, 16.
REQ-031 Stall: assert stall for 2 cycles while pc = 8 -> pc stays 8, IF/ID holds the instruction at PC 4, and fetching resumes at 8.
REQ-032 Redirect plus stall in the same cycle with redirect_pc = 0x40 -> next cycle pc = 0x40, if_id_valid = 0, if_id_instr = 0x13; the following cycle IF/ID holds imem[16].
REQ-033 Misaligned redirect to 0x22 -> pc = 0x20, misaligned_err = 1, and it stays 1 until rst is pulsed.
REQ-034 Reset mid-run at pc = 0x40 with flush = 1 -> next cycle pc = RESET_PC, if_id_valid = 0. With FETCH_PERF_CNT_EN defined, fetch_count = 0 after reset and equals 4 after four normal fetches.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage: PC register, async-read imem, IF/ID reg.
//            Optional perf counters under macro FETCH_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        misaligned_err
);

  localparam int          c_addr_w = $clog2(IMEM_DEPTH);
  localparam logic [31:0] c_nop    = 32'h0000_0013;

  logic [31:0] imem [0:IMEM_DEPTH-1];

  logic [31:0]         r_pc;
  logic [31:0]         r_if_id_pc;
  logic [31:0]         r_if_id_instr;
  logic                r_if_id_valid;
  logic                r_misaligned;
  logic [c_addr_w-1:0] w_idx;
  logic [31:0]         w_fetch_word;
  logic                w_capture;
  logic                w_bubble;

  // Upper PC bits are ignored, so out-of-range addresses wrap modulo depth.
  assign w_idx        = r_pc[c_addr_w+1:2];
  assign w_fetch_word = imem[w_idx];

  // A valid instruction enters IF/ID only on a plain (or flush-free) advance.
  assign w_capture = !redirect_valid && !stall && !flush;
  assign w_bubble  = redirect_valid || flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= c_nop;
      r_if_id_valid <= 1'b0;
      r_misaligned  <= 1'b0;
    end else begin
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        r_misaligned <= 1'b1;
      end

      if (redirect_valid) begin
        r_pc <= {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_capture) begin
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= w_fetch_word;
        r_if_id_valid <= 1'b1;
      end else if (w_bubble) begin
        r_if_id_instr <= c_nop;
        r_if_id_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'h0;
      r_stall_count <= 32'h0;
    end else begin
      if (w_capture) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (stall && !redirect_valid) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

  assign pc             = r_pc;
  assign if_id_pc       = r_if_id_pc;
  assign if_id_pc4      = r_if_id_pc + 32'd4;
  assign if_id_instr    = r_if_id_instr;
  assign if_id_valid    = r_if_id_valid;
  assign misaligned_err = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit: directed scenarios, then random.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 1024;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc, if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, misaligned_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count   (fetch_count),
    .stall_count   (stall_count),
`endif
    .misaligned_err(misaligned_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifpc4;
    logic [31:0] instr;
    logic        valid;
    logic        err;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference state, updated once per applied stimulus.
  logic [31:0] m_pc, m_ifpc, m_instr, m_fc, m_sc;
  logic        m_valid, m_err;

  function automatic logic [31:0] mem_at(input logic [31:0] addr);
    return mem[(addr / 4) % DEPTH];
  endfunction

  task automatic apply(input logic r, input logic s, input logic f,
                       input logic rv, input logic [31:0] rp);
    exp_t e;
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
    if (r) begin
      m_pc = RESET_PC; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_err = 0;
      m_fc = 0; m_sc = 0;
    end else if (rv) begin
      if (rp % 4 != 0) m_err = 1;
      m_pc = rp - (rp % 4);
      m_instr = NOP; m_valid = 0;
    end else if (s) begin
      m_sc = m_sc + 1;
      if (f) begin m_instr = NOP; m_valid = 0; end
    end else if (f) begin
      m_pc = m_pc + 4;
      m_instr = NOP; m_valid = 0;
    end else begin
      m_ifpc = m_pc; m_instr = mem_at(m_pc); m_valid = 1;
      m_fc = m_fc + 1;
      m_pc = m_pc + 4;
    end
    e.pc = m_pc; e.ifpc = m_ifpc; e.ifpc4 = m_ifpc + 4; e.instr = m_instr;
    e.valid = m_valid; e.err = m_err; e.fc = m_fc; e.sc = m_sc;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge the DUT presents a new IF/ID state; compare it.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      logic ok;
      e = sb_q.pop_front();
      ok = (pc === e.pc) && (if_id_pc === e.ifpc) && (if_id_pc4 === e.ifpc4) &&
           (if_id_instr === e.instr) && (if_id_valid === e.valid) &&
           (misaligned_err === e.err);
`ifdef FETCH_PERF_CNT_EN
      ok = ok && (fetch_count === e.fc) && (stall_count === e.sc);
`endif
      vectors = vectors + 1;
      if (!ok) begin
        miscompares = miscompares + 1;
        $display("FAIL step%0d: got pc=%h ifpc=%h ifpc4=%h instr=%h v=%b err=%b | want pc=%h ifpc=%h ifpc4=%h instr=%h v=%b err=%b",
                 vectors, pc, if_id_pc, if_id_pc4, if_id_instr, if_id_valid, misaligned_err,
                 e.pc, e.ifpc, e.ifpc4, e.instr, e.valid, e.err);
`ifdef FETCH_PERF_CNT_EN
        $display("  counters: got fc=%0d sc=%0d want fc=%0d sc=%0d",
                 fetch_count, stall_count, e.fc, e.sc);
`endif
      end
    end
  end

  initial begin
    logic [31:0] rp;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h13; mem[1] = 32'h93; mem[2] = 32'h113; mem[3] = 32'h193;
    for (int i = 0; i < DEPTH; i++) dut.imem[i] = mem[i];
    m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_err = 0; m_fc = 0; m_sc = 0;

    // Reset, then sequential fetch of imem[0..1] (pc 4, 8)
    apply(1, 0, 0, 0, 0);
    apply(1, 1, 1, 1, 32'h44);
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    // Two-cycle stall at pc=8, then resume
    apply(0, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    // Redirect wins over stall and flush
    apply(0, 1, 1, 1, 32'h40);
    apply(0, 0, 0, 0, 0);
    // Misaligned redirect sets a sticky flag
    apply(0, 0, 0, 1, 32'h22);
    apply(0, 0, 0, 0, 0);
    apply(0, 1, 1, 0, 0);
    apply(0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 32'h40);
    // Reset mid-run with flush, then four normal fetches
    apply(1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 0);
    // PC wrap from the top of the address space
    apply(0, 0, 0, 1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: rp = $urandom;
        1: rp = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: rp = $urandom_range(0, 8191);
      endcase
      apply($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, rp);
    end

    rst = 0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() > 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
